load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 tb/tb_load_store_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit for a big-endian, byte-addressed data memory.
// Handles byte/half read-modify-write, load extension and access errors.
module load_store_unit #(
    parameter int ADDR_LIMIT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqStore,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqAddress,
    input  logic [31:0] reqData,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respData,
    output logic        respError,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] memReadData
);

    localparam logic [31:0] LIMIT = ADDR_LIMIT;

    typedef enum logic [2:0] {
        IDLE, LOAD, RMW_READ, WRITE, RESP
    } state_t;

    state_t state, stateNext;

    logic [1:0]  opSize;
    logic        opUnsigned;
    logic [1:0]  offset;
    logic [15:0] storeData;
    logic        accept;
    logic        reqError;
    logic [31:0] wordBase;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] loadValue;
    logic [31:0] mergedWord;

    assign accept   = reqValid && (state == IDLE);
    assign wordBase = {reqAddress[31:2], 2'b00};

    always_comb begin
        reqError = 1'b0;
        if (reqSize == 2'b11)
            reqError = 1'b1;
        else if (reqSize == 2'b01 && reqAddress[0])
            reqError = 1'b1;
        else if (reqSize == 2'b10 && reqAddress[1:0] != 2'b00)
            reqError = 1'b1;
        else if (wordBase >= LIMIT)
            reqError = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (reqValid) begin
                    if (reqError)
                        stateNext = RESP;
                    else if (!reqStore)
                        stateNext = LOAD;
                    else if (reqSize == 2'b10)
                        stateNext = WRITE;
                    else
                        stateNext = RMW_READ;
                end
            end
            LOAD:     stateNext = RESP;
            RMW_READ: stateNext = WRITE;
            WRITE:    stateNext = RESP;
            RESP:     if (respReady) stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    // Strobes decode from state so reset kills them asynchronously
    assign reqReady  = (state == IDLE);
    assign respValid = (state == RESP);
    assign memRead   = (state == LOAD) || (state == RMW_READ);
    assign memWrite  = (state == WRITE);

    always_comb begin
        laneByte = memReadData[7:0];
        unique case (offset)
            2'd0: laneByte = memReadData[31:24];
            2'd1: laneByte = memReadData[23:16];
            2'd2: laneByte = memReadData[15:8];
            2'd3: laneByte = memReadData[7:0];
            default: laneByte = memReadData[7:0];
        endcase
        laneHalf = offset[1] ? memReadData[15:0] : memReadData[31:16];
    end

    always_comb begin
        loadValue = memReadData;
        unique case (opSize)
            2'b00: loadValue = {{24{~opUnsigned & laneByte[7]}}, laneByte};
            2'b01: loadValue = {{16{~opUnsigned & laneHalf[15]}}, laneHalf};
            default: loadValue = memReadData;
        endcase
    end

    always_comb begin
        mergedWord = memReadData;
        if (opSize == 2'b00) begin
            unique case (offset)
                2'd0: mergedWord[31:24] = storeData[7:0];
                2'd1: mergedWord[23:16] = storeData[7:0];
                2'd2: mergedWord[15:8]  = storeData[7:0];
                2'd3: mergedWord[7:0]   = storeData[7:0];
                default: mergedWord = memReadData;
            endcase
        end else if (offset[1]) begin
            mergedWord[15:0] = storeData;
        end else begin
            mergedWord[31:16] = storeData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opSize       <= 2'b00;
            opUnsigned   <= 1'b0;
            offset       <= 2'b00;
            storeData    <= 16'h0;
            memAddress   <= 32'h0;
            memWriteData <= 32'h0;
            respData     <= 32'h0;
            respError    <= 1'b0;
        end else if (accept) begin
            opSize       <= reqSize;
            opUnsigned   <= reqUnsigned;
            offset       <= reqAddress[1:0];
            storeData    <= reqData[15:0];
            memAddress   <= wordBase;
            memWriteData <= reqData;
            respData     <= 32'h0;
            respError    <= reqError;
        end else if (state == LOAD) begin
            respData <= loadValue;
        end else if (state == RMW_READ) begin
            memWriteData <= mergedWord;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word big-endian memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqStore = 1'b0;
    logic [1:0]  reqSize = 2'b00;
    logic        reqUnsigned = 1'b0;
    logic [31:0] reqAddress = 32'h0;
    logic [31:0] reqData = 32'h0;
    logic        respValid;
    logic        respReady = 1'b0;
    logic [31:0] respData;
    logic        respError;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memReadData;

    logic [31:0] memArr [64];
    logic        initMem = 1'b1;
    int          readCount = 0;
    int          writeCount = 0;
    logic [31:0] lastWriteAddr = 32'h0;
    logic [31:0] lastWriteData = 32'h0;

    int checks = 0;
    int failures = 0;

    load_store_unit #(.ADDR_LIMIT(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady),
        .reqStore(reqStore), .reqSize(reqSize),
        .reqUnsigned(reqUnsigned), .reqAddress(reqAddress),
        .reqData(reqData), .respValid(respValid),
        .respReady(respReady), .respData(respData),
        .respError(respError), .memAddress(memAddress),
        .memWriteData(memWriteData), .memRead(memRead),
        .memWrite(memWrite), .memReadData(memReadData)
    );

    always #5 clk = ~clk;

    assign memReadData = memArr[memAddress[7:2]];

    always @(posedge clk) begin
        if (initMem) begin
            for (int i = 0; i < 64; i++)
                memArr[i] <= 32'hDEAD0000 + 32'(i);
        end else if (memWrite) begin
            memArr[memAddress[7:2]] <= memWriteData;
        end
        if (memRead) readCount = readCount + 1;
        if (memWrite) begin
            writeCount = writeCount + 1;
            lastWriteAddr = memAddress;
            lastWriteData = memWriteData;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input logic st, input logic [1:0] sz,
                          input logic un, input logic [31:0] addr,
                          input logic [31:0] data, input int expLat,
                          input logic [31:0] expData, input logic expErr,
                          input int expR, input int expW,
                          input string tag);
        int lat;
        int r0;
        int w0;
        @(negedge clk);
        r0 = readCount;
        w0 = writeCount;
        check({tag, " reqReady"}, 32'(reqReady), 32'd1);
        reqValid = 1'b1;
        reqStore = st;
        reqSize = sz;
        reqUnsigned = un;
        reqAddress = addr;
        reqData = data;
        @(posedge clk);
        #1 reqValid = 1'b0;
        lat = 0;
        while (respValid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(expLat));
        check({tag, " respData"}, respData, expData);
        check({tag, " respError"}, 32'(respError), 32'(expErr));
        @(negedge clk);
        respReady = 1'b1;
        @(posedge clk);
        #1 respReady = 1'b0;
        check({tag, " back idle"}, 32'(reqReady), 32'd1);
        check({tag, " reads"}, 32'(readCount - r0), 32'(expR));
        check({tag, " writes"}, 32'(writeCount - w0), 32'(expW));
    endtask

    initial begin
        int w0;
        #2;
        check("rst reqReady", 32'(reqReady), 32'd1);
        check("rst respValid", 32'(respValid), 32'd0);
        check("rst respData", respData, 32'h0);
        check("rst respError", 32'(respError), 32'd0);
        check("rst memRead", 32'(memRead), 32'd0);
        check("rst memWrite", 32'(memWrite), 32'd0);
        check("rst memAddress", memAddress, 32'h0);
        check("rst memWriteData", memWriteData, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        initMem = 1'b0;
        rst_n = 1'b1;

        access(1, 2'b10, 0, 32'd20, 32'h11223344, 1, 32'h0, 0, 0, 1, "SW20");
        check("SW20 addr", lastWriteAddr, 32'd20);
        check("SW20 wdata", lastWriteData, 32'h11223344);
        access(0, 2'b10, 0, 32'd20, 32'h0, 1, 32'h11223344, 0, 1, 0, "LW20a");

        access(1, 2'b00, 0, 32'd21, 32'h000000AB, 2, 32'h0, 0, 1, 1, "SB21");
        check("SB21 wdata", lastWriteData, 32'h11AB3344);
        check("SB21 addr", lastWriteAddr, 32'd20);
        access(0, 2'b10, 0, 32'd20, 32'h0, 1, 32'h11AB3344, 0, 1, 0, "LW20b");

        access(0, 2'b00, 0, 32'd21, 32'h0, 1, 32'hFFFFFFAB, 0, 1, 0, "LB21");
        access(0, 2'b00, 1, 32'd21, 32'h0, 1, 32'h000000AB, 0, 1, 0, "LBU21");
        access(0, 2'b01, 0, 32'd22, 32'h0, 1, 32'h00003344, 0, 1, 0, "LH22");
        access(1, 2'b01, 0, 32'd20, 32'h00008001, 2, 32'h0, 0, 1, 1, "SH20");
        check("SH20 wdata", lastWriteData, 32'h80013344);
        access(0, 2'b01, 0, 32'd20, 32'h0, 1, 32'hFFFF8001, 0, 1, 0, "LH20");
        access(0, 2'b01, 1, 32'd20, 32'h0, 1, 32'h00008001, 0, 1, 0, "LHU20");

        access(0, 2'b10, 0, 32'd22, 32'h0, 0, 32'h0, 1, 0, 0, "errLW22");
        access(0, 2'b01, 0, 32'd23, 32'h0, 0, 32'h0, 1, 0, 0, "errLH23");
        access(1, 2'b11, 0, 32'd20, 32'hFFFFFFFF, 0, 32'h0, 1, 0, 0, "errSz3");
        access(0, 2'b10, 0, 32'd256, 32'h0, 0, 32'h0, 1, 0, 0, "errLW256");
        access(1, 2'b10, 0, 32'd300, 32'h12345678, 0, 32'h0, 1, 0, 0, "errSW300");
        access(0, 2'b10, 0, 32'd20, 32'h0, 1, 32'h80013344, 0, 1, 0, "LW20c");

        // Response back-pressure with a competing request held high
        @(negedge clk);
        w0 = writeCount;
        reqValid = 1'b1;
        reqStore = 1'b0;
        reqSize = 2'b10;
        reqUnsigned = 1'b0;
        reqAddress = 32'd20;
        @(posedge clk);
        #1 reqStore = 1'b1;
        reqAddress = 32'd24;
        reqData = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check("hold respValid", 32'(respValid), 32'd1);
            check("hold respData", respData, 32'h80013344);
            check("hold respError", 32'(respError), 32'd0);
            check("hold reqReady", 32'(reqReady), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        reqValid = 1'b0;
        respReady = 1'b1;
        @(posedge clk);
        #1 respReady = 1'b0;
        check("hold release idle", 32'(reqReady), 32'd1);
        check("hold release respValid", 32'(respValid), 32'd0);
        check("hold no write", 32'(writeCount - w0), 32'd0);

        // Reset lands during the read half of a byte store
        @(negedge clk);
        w0 = writeCount;
        reqValid = 1'b1;
        reqStore = 1'b1;
        reqSize = 2'b00;
        reqAddress = 32'd24;
        reqData = 32'h00000055;
        @(posedge clk);
        #1 reqValid = 1'b0;
        check("rmw memRead", 32'(memRead), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst memRead drop", 32'(memRead), 32'd0);
        check("rst memWrite low", 32'(memWrite), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post rst reqReady", 32'(reqReady), 32'd1);
        check("post rst respValid", 32'(respValid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("post rst no write", 32'(writeCount - w0), 32'd0);
        access(0, 2'b10, 0, 32'd24, 32'h0, 1, 32'hDEAD0006, 0, 1, 0, "LW24");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
